// File: rtl/pg_mmio2csr.sv
// rtl/pg_mmio2csr.sv - Port-gasket MMIO endpoint: single-beat AXI4 to one-cycle CSR strobes
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   aw*/w*/b*             AXI4 write address, write data and write response channels
//   ar*/r*                AXI4 read address and read data channels
//   csr_wr, csr_rd        one-cycle CSR write/read strobes
//   csr_addr              CSR byte address, low three bits forced to zero
//   csr_wdata, csr_wstrb  CSR write data and byte strobes
//   csr_rdata_valid       CSR read data valid, only observed while waiting for read data
//   csr_rdata             CSR read data
module pg_mmio2csr #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 10,
  parameter int RD_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic [2:0]          awprot,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic [2:0]          arprot,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic                csr_wr,
  output logic                csr_rd,
  output logic [ADDR_W-1:0]   csr_addr,
  output logic [DATA_W-1:0]   csr_wdata,
  output logic [DATA_W/8-1:0] csr_wstrb,
  input  logic                csr_rdata_valid,
  input  logic [DATA_W-1:0]   csr_rdata
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int          TCNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_CSR, WR_RESP, RD_CSR, RD_WAIT, RD_RESP
  } state_t;

  state_t              state_q, state_d;
  logic                err_q, err_d;
  logic [7:0]          len_q, len_d;
  logic [8:0]          beat_q, beat_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                last_wr_q, last_wr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                awready_q, awready_d;
  logic                arready_q, arready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                csr_wr_q, csr_wr_d;
  logic                csr_rd_q, csr_rd_d;
  logic [ADDR_W-1:0]   csr_addr_q, csr_addr_d;
  logic [DATA_W-1:0]   csr_wdata_q, csr_wdata_d;
  logic [STRB_W-1:0]   csr_wstrb_q, csr_wstrb_d;
  logic                aw_err, ar_err, w_err;

  // burst/prot and the sub-word address bits carry no meaning for 64-bit CSRs
  logic unused_inputs;
  assign unused_inputs = ^{awburst, awprot, arburst, arprot, awaddr[2:0], araddr[2:0]};

  assign aw_err = (awlen != 8'd0) || (awsize != 3'd3);
  assign ar_err = (arlen != 8'd0) || (arsize != 3'd3);

  // Every output is the Q of a register; the next-state logic computes the
  // value each output takes in the following cycle together with the state.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tcnt_d      = tcnt_q;
    last_wr_d   = last_wr_q;
    id_d        = id_q;
    awready_d   = 1'b0;
    arready_d   = 1'b0;
    wready_d    = 1'b0;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    csr_wr_d    = 1'b0;
    csr_rd_d    = 1'b0;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_wstrb_d = csr_wstrb_q;
    w_err       = err_q | ~wlast;

    unique case (state_q)
      IDLE: begin
        if (awready_q && awvalid) begin
          state_d   = WR_DATA;
          wready_d  = 1'b1;
          id_d      = awid;
          len_d     = awlen;
          beat_d    = 9'd0;
          err_d     = aw_err;
          last_wr_d = 1'b1;
          if (!aw_err) begin
            csr_addr_d = {awaddr[ADDR_W-1:3], 3'b000};
          end
        end else if (arready_q && arvalid) begin
          id_d      = arid;
          len_d     = arlen;
          beat_d    = 9'd0;
          err_d     = ar_err;
          last_wr_d = 1'b0;
          if (ar_err) begin
            // Drain path: answer arlen+1 zero beats without touching the CSR
            state_d  = RD_RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            rlast_d  = (arlen == 8'd0);
          end else begin
            state_d    = RD_CSR;
            csr_rd_d   = 1'b1;
            csr_addr_d = {araddr[ADDR_W-1:3], 3'b000};
          end
        end else if (awready_q) begin
          awready_d = 1'b1;
        end else if (arready_q) begin
          arready_d = 1'b1;
        end else if (awvalid && (!arvalid || !last_wr_q)) begin
          // On a contest the channel that was not served last wins
          awready_d = 1'b1;
        end else if (arvalid) begin
          arready_d = 1'b1;
        end
      end

      WR_DATA: begin
        wready_d = 1'b1;
        if (wvalid && wready_q) begin
          beat_d = beat_q + 9'd1;
          if (!err_q) begin
            csr_wdata_d = wdata;
            csr_wstrb_d = wstrb;
            err_d       = w_err;
          end
          if (wlast || (beat_q == {1'b0, len_q})) begin
            wready_d = 1'b0;
            if (w_err && !(err_q == 1'b0 && wlast)) begin
              state_d  = WR_RESP;
              bvalid_d = 1'b1;
              bresp_d  = RESP_SLVERR;
            end else begin
              state_d  = WR_CSR;
              csr_wr_d = 1'b1;
            end
          end
        end
      end

      WR_CSR: begin
        state_d  = WR_RESP;
        bvalid_d = 1'b1;
        bresp_d  = RESP_OKAY;
      end

      WR_RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end

      RD_CSR: begin
        state_d = RD_WAIT;
        tcnt_d  = '0;
      end

      RD_WAIT: begin
        if (csr_rdata_valid) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = csr_rdata;
          rresp_d  = RESP_OKAY;
          rlast_d  = 1'b1;
        end else if (tcnt_q == TCNT_W'(RD_TIMEOUT - 1)) begin
          // Counter has covered RD_TIMEOUT wait cycles without an answer
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '1;
          rresp_d  = RESP_SLVERR;
          rlast_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      RD_RESP: begin
        if (rready) begin
          if (beat_q != {1'b0, len_q}) begin
            beat_d  = beat_q + 9'd1;
            rlast_d = ((beat_q + 9'd1) == {1'b0, len_q});
          end else begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            rlast_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_q       <= 1'b0;
      len_q       <= '0;
      beat_q      <= '0;
      tcnt_q      <= '0;
      last_wr_q   <= 1'b0;
      id_q        <= '0;
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      csr_wr_q    <= 1'b0;
      csr_rd_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tcnt_q      <= tcnt_d;
      last_wr_q   <= last_wr_d;
      id_q        <= id_d;
      awready_q   <= awready_d;
      arready_q   <= arready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      csr_wr_q    <= csr_wr_d;
      csr_rd_q    <= csr_rd_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_wstrb_q <= csr_wstrb_d;
    end
  end

  // The captured ID is the response tag for whichever channel is active
  assign awready   = awready_q;
  assign arready   = arready_q;
  assign wready    = wready_q;
  assign bid       = id_q;
  assign bresp     = bresp_q;
  assign bvalid    = bvalid_q;
  assign rid       = id_q;
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign rlast     = rlast_q;
  assign rvalid    = rvalid_q;
  assign csr_wr    = csr_wr_q;
  assign csr_rd    = csr_rd_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;
  assign csr_wstrb = csr_wstrb_q;

endmodule
